motoro3_pwm_meter: RTL and testbench

Receive-side companion to the motoro3 PWM generator: samples a PWM waveform (the generator's own output looped back, or the gate-driver feedback pin) and measures its high time and period in clk cycles. It also accumulates total on-time per commutation step window, so firmware can compare the delivered on-time against the requested on-time. It sits beside the generator in the motoro3 core and runs on the same 10 MHz clock.

---
 rtl/motoro3_pwm_meter.sv | 166 ++++++++++++++++
 tb/tb_motoro3_pwm_meter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_pwm_meter.sv
// PWM receive-side meter: filters a looped-back PWM input, measures high time and period,
// and accumulates filtered on-time per commutation step window. All state updates on falling clk.
module motoro3_pwm_meter #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             pwmIn,
  input  logic             measEn,
  input  logic             winClr,
  input  logic [CNT_W-1:0] m3r_pwmTimeout,
  output logic [CNT_W-1:0] hiLen,
  output logic [CNT_W-1:0] perLen,
  output logic             measValid,
  output logic             measTimeout,
  output logic             stuckLevel,
  output logic [CNT_W-1:0] winOnSum,
  output logic             winOnSumValid
);

  localparam int unsigned      FILT_W   = 4;
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } stateT;

  logic [1:0]        syncQ;
  logic [FILT_W-1:0] filtCnt;
  logic              pwmF;
  logic              pwmFD;
  stateT             state;
  logic [CNT_W-1:0]  hiCnt;
  logic [CNT_W-1:0]  perCnt;
  logic [CNT_W-1:0]  winAcc;

  logic              pRise;
  logic              pFall;
  logic              tmoHit;
  logic [CNT_W-1:0]  hiInc;
  logic [CNT_W-1:0]  perInc;

  // Synchronizer, then a run-length filter: pwmF follows only after FILT_LEN differing samples.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      syncQ   <= '0;
      filtCnt <= '0;
      pwmF    <= 1'b0;
      pwmFD   <= 1'b0;
    end else begin
      syncQ <= {syncQ[0], pwmIn};
      pwmFD <= pwmF;
      if (syncQ[1] == pwmF) begin
        filtCnt <= '0;
      end else if (filtCnt == FILT_MAX) begin
        pwmF    <= syncQ[1];
        filtCnt <= '0;
      end else begin
        filtCnt <= filtCnt + FILT_W'(1);
      end
    end
  end

  always_comb begin
    pRise  = pwmF & ~pwmFD;
    pFall  = ~pwmF & pwmFD;
    hiInc  = (hiCnt == CNT_MAX) ? hiCnt : hiCnt + CNT_ONE;
    perInc = (perCnt == CNT_MAX) ? perCnt : perCnt + CNT_ONE;
    tmoHit = (m3r_pwmTimeout != '0) && (state != IDLE) && (perCnt == m3r_pwmTimeout);
  end

  // Measurement FSM; the cycle carrying pFall is counted as period only, which keeps hiLen exact.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      hiCnt       <= '0;
      perCnt      <= '0;
      hiLen       <= '0;
      perLen      <= '0;
      measValid   <= 1'b0;
      measTimeout <= 1'b0;
      stuckLevel  <= 1'b0;
    end else begin
      measValid   <= 1'b0;
      measTimeout <= 1'b0;
      if (!measEn) begin
        state  <= IDLE;
        hiCnt  <= '0;
        perCnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (pRise) begin
              hiCnt  <= CNT_ONE;
              perCnt <= CNT_ONE;
              state  <= HIGH;
            end
          end
          HIGH: begin
            if (tmoHit) begin
              measTimeout <= 1'b1;
              stuckLevel  <= pwmF;
              hiCnt       <= '0;
              perCnt      <= '0;
              state       <= IDLE;
            end else begin
              perCnt <= perInc;
              if (pFall) begin
                state <= LOW;
              end else begin
                hiCnt <= hiInc;
              end
            end
          end
          LOW: begin
            // A rise coinciding with the timeout completes the measurement instead.
            if (pRise) begin
              hiLen     <= hiCnt;
              perLen    <= perCnt;
              measValid <= 1'b1;
              hiCnt     <= CNT_ONE;
              perCnt    <= CNT_ONE;
              state     <= HIGH;
            end else if (tmoHit) begin
              measTimeout <= 1'b1;
              stuckLevel  <= pwmF;
              hiCnt       <= '0;
              perCnt      <= '0;
              state       <= IDLE;
            end else begin
              perCnt <= perInc;
            end
          end
          default: begin
            state  <= IDLE;
            hiCnt  <= '0;
            perCnt <= '0;
          end
        endcase
      end
    end
  end

  // Window on-time accumulator; the clear cycle itself is never counted.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      winAcc        <= '0;
      winOnSum      <= '0;
      winOnSumValid <= 1'b0;
    end else begin
      winOnSumValid <= winClr;
      if (winClr) begin
        winOnSum <= winAcc;
        winAcc   <= '0;
      end else if (pwmF && (winAcc != CNT_MAX)) begin
        winAcc <= winAcc + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_meter.sv
// Directed bench for motoro3_pwm_meter: vector table of PWM shapes plus hand-built
// glitch, timeout, enable, reset and window sequences.
`timescale 1ns/1ps
module tb_motoro3_pwm_meter;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             nRst;
  logic             pwmIn;
  logic             measEn;
  logic             winClr;
  logic [CNT_W-1:0] tmo;
  logic [CNT_W-1:0] hiLen;
  logic [CNT_W-1:0] perLen;
  logic             measValid;
  logic             measTimeout;
  logic             stuckLevel;
  logic [CNT_W-1:0] winOnSum;
  logic             winOnSumValid;

  motoro3_pwm_meter #(.FILT_LEN(3), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .nRst           (nRst),
    .pwmIn          (pwmIn),
    .measEn         (measEn),
    .winClr         (winClr),
    .m3r_pwmTimeout (tmo),
    .hiLen          (hiLen),
    .perLen         (perLen),
    .measValid      (measValid),
    .measTimeout    (measTimeout),
    .stuckLevel     (stuckLevel),
    .winOnSum       (winOnSum),
    .winOnSumValid  (winOnSumValid)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] p;
  } pulseT;

  typedef struct {
    int unsigned hi;
    int unsigned lo;
    int unsigned tmoVal;
    int unsigned nPer;
    int unsigned expHi;
    int unsigned expPer;
  } vecT;

  pulseT pulseQ[$];
  int    rdIdx   = 0;
  int    tmoCnt  = 0;
  int    dblCnt  = 0;
  int    checks  = 0;
  int    errors  = 0;
  logic  prevMv  = 1'b0;
  logic  prevTo  = 1'b0;
  logic  prevWv  = 1'b0;

  // Outputs change on the falling edge, so they are observed on the rising edge.
  always @(posedge clk) begin
    if (measValid) pulseQ.push_back({hiLen, perLen});
    if (measTimeout) tmoCnt <= tmoCnt + 1;
    if ((measValid && prevMv) || (measTimeout && prevTo) || (winOnSumValid && prevWv))
      dblCnt <= dblCnt + 1;
    prevMv <= measValid;
    prevTo <= measTimeout;
    prevWv <= winOnSumValid;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    pwmIn = lvl;
    repeat (n) @(posedge clk);
  endtask

  task automatic expectPulse(input string name, input int unsigned eh, input int unsigned ep);
    check({name, " pulse present"}, longint'(pulseQ.size() > rdIdx), 1);
    if (pulseQ.size() > rdIdx) begin
      check({name, " hiLen"}, longint'(pulseQ[rdIdx].h), longint'(eh));
      check({name, " perLen"}, longint'(pulseQ[rdIdx].p), longint'(ep));
      rdIdx++;
    end
  endtask

  task automatic expectNoMore(input string name);
    check({name, " extra pulses"}, longint'(pulseQ.size() - rdIdx), 0);
  endtask

  vecT vecs[6];

  initial begin
    int tmoBase;
    int hits;
    int hitAt;
    bit pend;
    bit valChk;
    int unsigned expSum;

    vecs[0] = '{32, 480,   0, 3,  32,   512};
    vecs[1] = '{32, 480, 600, 2,  32,   512};
    vecs[2] = '{10,  20,  30, 3,  10,    30};
    vecs[3] = '{ 4,   4,   0, 4,   4,     8};
    vecs[4] = '{ 7,  13,   0, 3,   7,    20};
    vecs[5] = '{100, 65500, 0, 1, 100, 65535};

    nRst = 1'b1; pwmIn = 1'b0; measEn = 1'b0; winClr = 1'b0; tmo = '0;
    #10 nRst = 1'b0;
    repeat (3) @(posedge clk);
    check("reset hiLen", hiLen, 0);
    check("reset perLen", perLen, 0);
    check("reset measValid", measValid, 0);
    check("reset measTimeout", measTimeout, 0);
    check("reset stuckLevel", stuckLevel, 0);
    check("reset winOnSum", winOnSum, 0);
    check("reset winOnSumValid", winOnSumValid, 0);
    nRst = 1'b1;
    drive(1'b0, 5);

    // Clean PWM shapes: first rise arms, each later rise reports one period.
    for (int v = 0; v < 6; v++) begin
      measEn = 1'b0;
      tmo = CNT_W'(vecs[v].tmoVal);
      drive(1'b0, 20);
      rdIdx = pulseQ.size();
      tmoBase = tmoCnt;
      measEn = 1'b1;
      drive(1'b0, 5);
      repeat (vecs[v].nPer) begin
        drive(1'b1, int'(vecs[v].hi));
        drive(1'b0, int'(vecs[v].lo));
      end
      drive(1'b1, int'(vecs[v].hi));
      drive(1'b0, 8);
      for (int k = 0; k < int'(vecs[v].nPer); k++)
        expectPulse($sformatf("vec%0d p%0d", v, k), vecs[v].expHi, vecs[v].expPer);
      expectNoMore($sformatf("vec%0d", v));
      check($sformatf("vec%0d timeouts", v), tmoCnt - tmoBase, 0);
    end

    // Glitches: 2-cycle low glitch filtered out, 3-cycle one splits the period.
    measEn = 1'b0; tmo = '0;
    drive(1'b0, 20);
    rdIdx = pulseQ.size();
    measEn = 1'b1;
    drive(1'b0, 5);
    drive(1'b1, 32); drive(1'b0, 480);
    drive(1'b1, 15); drive(1'b0, 2); drive(1'b1, 15); drive(1'b0, 480);
    drive(1'b1, 15); drive(1'b0, 3); drive(1'b1, 14); drive(1'b0, 480);
    drive(1'b1, 32); drive(1'b0, 20);
    expectPulse("glitch clean", 32, 512);
    expectPulse("glitch2", 32, 512);
    expectPulse("glitch3 split", 15, 18);
    expectPulse("glitch3 rest", 14, 494);
    expectNoMore("glitch");

    // Timeout with the input stuck high after one rise.
    measEn = 1'b0; tmo = CNT_W'(1000);
    drive(1'b0, 20);
    rdIdx = pulseQ.size();
    tmoBase = tmoCnt;
    measEn = 1'b1;
    drive(1'b0, 5);
    pwmIn = 1'b1;
    hits = 0; hitAt = 0;
    for (int i = 1; i <= 1010; i++) begin
      @(posedge clk);
      if (measTimeout) begin
        hits++;
        hitAt = i;
      end
    end
    check("timeout pulses", hits, 1);
    check("timeout cycle", hitAt, 1006);
    check("stuckLevel", stuckLevel, 1);
    drive(1'b1, 200); drive(1'b0, 100);
    drive(1'b1, 32); drive(1'b0, 480);
    drive(1'b1, 32); drive(1'b0, 20);
    expectPulse("after timeout", 32, 512);
    expectNoMore("after timeout");
    check("timeout total", tmoCnt - tmoBase, 1);

    // Enable dropped in LOW: results hold and the meter must re-arm.
    measEn = 1'b0; tmo = '0;
    drive(1'b0, 20);
    rdIdx = pulseQ.size();
    measEn = 1'b1;
    drive(1'b0, 20);
    drive(1'b1, 20); drive(1'b0, 300);
    drive(1'b1, 20); drive(1'b0, 150);
    measEn = 1'b0;
    drive(1'b0, 10);
    check("hold hiLen", hiLen, 20);
    check("hold perLen", perLen, 320);
    measEn = 1'b1;
    drive(1'b0, 140);
    drive(1'b1, 20); drive(1'b0, 300);
    drive(1'b1, 20); drive(1'b0, 20);
    expectPulse("enable first", 20, 320);
    expectPulse("enable rearm", 20, 320);
    expectNoMore("enable");

    // Asynchronous reset while in HIGH.
    drive(1'b0, 20);
    drive(1'b1, 32); drive(1'b0, 480);
    pwmIn = 1'b1;
    repeat (15) @(posedge clk);
    check("pre-reset hiLen", hiLen, 32);
    nRst = 1'b0;
    pwmIn = 1'b0;
    #1;
    check("mid reset hiLen", hiLen, 0);
    check("mid reset perLen", perLen, 0);
    check("mid reset measValid", measValid, 0);
    check("mid reset measTimeout", measTimeout, 0);
    check("mid reset stuckLevel", stuckLevel, 0);
    check("mid reset winOnSum", winOnSum, 0);
    check("mid reset winOnSumValid", winOnSumValid, 0);
    repeat (3) @(posedge clk);
    nRst = 1'b1;
    rdIdx = pulseQ.size();
    drive(1'b0, 20);
    drive(1'b1, 32); drive(1'b0, 480);
    drive(1'b1, 32); drive(1'b0, 480);
    drive(1'b1, 32); drive(1'b0, 20);
    expectPulse("post reset", 32, 512);
    expectPulse("post reset 2", 32, 512);
    expectNoMore("post reset");

    // Window accumulation with measEn low; pwmF is high in cycles c where (c-5)%512 < 32.
    measEn = 1'b0;
    drive(1'b0, 20);
    pend = 1'b0; valChk = 1'b0; expSum = 0;
    for (int c = 0; c < 6700; c++) begin
      if (pend) begin
        check($sformatf("winOnSumValid @%0d", c), winOnSumValid, 1);
        if (valChk) check($sformatf("winOnSum @%0d", c), winOnSum, longint'(expSum));
        pend = 1'b0;
      end
      pwmIn = ((c % 512) < 32);
      winClr = 1'b0;
      case (c)
        100:  begin winClr = 1'b1; pend = 1'b1; valChk = 1'b0; end
        5220: begin winClr = 1'b1; pend = 1'b1; valChk = 1'b1; expSum = 320; end
        6164: begin winClr = 1'b1; pend = 1'b1; valChk = 1'b1; expSum = 47;  end
        6676: begin winClr = 1'b1; pend = 1'b1; valChk = 1'b1; expSum = 31;  end
        default: ;
      endcase
      @(posedge clk);
    end
    winClr = 1'b0;
    drive(1'b0, 10);

    check("no back-to-back pulses", dblCnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
